// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default baud divider and receiver states.
// The default divider is shared with the transmitter so both ends agree on baud.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 87;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// N-stage synchronizer for asynchronous inputs; presets to 1 on reset so an
// idle-high line does not look like activity when reset is released.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receiver, 8N1 LSB first with mid-bit sampling; defining UART_RX_PARITY_EN
// switches to 8E1 and adds the o_Parity_err output.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_Rx_serial,
    output logic       o_Rx_dv,
    output logic [7:0] o_Rx_byte,
    output logic       o_Frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       o_Parity_err,
`endif
    output logic       o_Rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_START  = START;
    localparam logic [2:0] S_DATA   = DATA;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = PARITY;
`endif
    localparam logic [2:0] S_STOP   = STOP;
    localparam logic [2:0] S_BREAK  = BREAK;

    logic                      rx_s;
    logic [2:0]                state;
    logic [CNT_W-1:0]          clk_cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift_reg;
`ifdef UART_RX_PARITY_EN
    logic                      parity_bad;
`endif

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (i_Rx_serial),
        .q    (rx_s)
    );

    // Returning to IDLE at the stop-bit mid-sample leaves half a bit of slack
    // for the next start edge, which is what makes back-to-back frames work.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            o_Rx_dv     <= 1'b0;
            o_Rx_byte   <= 8'h00;
            o_Frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad   <= 1'b0;
            o_Parity_err <= 1'b0;
`endif
        end else begin
            o_Rx_dv     <= 1'b0;
            o_Frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_Parity_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (!rx_s) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (clk_cnt == HALF_BIT) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (clk_cnt == BIT_END) begin
                        clk_cnt            <= '0;
                        shift_reg[bit_idx] <= rx_s;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (clk_cnt == BIT_END) begin
                        clk_cnt    <= '0;
                        parity_bad <= rx_s ^ (^shift_reg);
                        state      <= S_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (clk_cnt == BIT_END) begin
                        clk_cnt <= '0;
                        if (!rx_s) begin
                            o_Frame_err <= 1'b1;
                            state       <= S_BREAK;
`ifdef UART_RX_PARITY_EN
                        end else if (parity_bad) begin
                            o_Parity_err <= 1'b1;
                            state        <= S_IDLE;
`endif
                        end else begin
                            o_Rx_byte <= shift_reg;
                            o_Rx_dv   <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                // A line held low after a bad stop bit is a break, not new frames.
                S_BREAK: begin
                    clk_cnt <= '0;
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    clk_cnt <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign o_Rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed self-checking bench for uart_rx_sampler at CLKS_PER_BIT=16, SYNC_STAGES=2;
// exercises the parity path too when UART_RX_PARITY_EN is defined.
module tb_uart_rx_sampler;

    localparam int CPB  = 16;
    localparam int SYNC = 2;
    localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int LATENCY = SYNC + HALF + (FRAME_BITS - 1) * CPB + 2;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       dv;
    logic [7:0] rx_byte;
    logic       ferr;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       perr;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int         dv_cnt      = 0;
    int         err_cnt     = 0;
    int         perr_cnt    = 0;
    int         overlap_cnt = 0;
    logic [7:0] dv_bytes[$];
    int         dv_cycs[$];

    uart_rx_sampler #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_Rx_serial (rx),
        .o_Rx_dv     (dv),
        .o_Rx_byte   (rx_byte),
        .o_Frame_err (ferr),
`ifdef UART_RX_PARITY_EN
        .o_Parity_err(perr),
`endif
        .o_Rx_busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (dv === 1'b1) begin
            dv_cnt++;
            dv_bytes.push_back(rx_byte);
            dv_cycs.push_back(cyc);
        end
        if (ferr === 1'b1) err_cnt++;
        if (dv === 1'b1 && ferr === 1'b1) overlap_cnt++;
`ifdef UART_RX_PARITY_EN
        if (perr === 1'b1) perr_cnt++;
`endif
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bz) rx = 1'b1;
`endif
        send_bit(stop);
    endtask

    task automatic send_good(input logic [7:0] data);
        send_frame(data, ^data, 1'b1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (dv !== 1'b0) $display("[TB] FAIL reset_dv: got %b expected 0", dv);
        else n_pass++;
        n_checks++;
        if (ferr !== 1'b0) $display("[TB] FAIL reset_ferr: got %b expected 0", ferr);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        else n_pass++;
        n_checks++;
        if (rx_byte !== 8'h00) $display("[TB] FAIL reset_byte: got %h expected 00", rx_byte);
        else n_pass++;
        rst_n = 1'b1;
        idle(5);
    endtask

    task automatic test_single_frame;
        int b, e, qi, t0;
        logic [7:0] got;
        int lat;
        b  = dv_cnt;
        e  = err_cnt;
        qi = dv_bytes.size();
        t0 = cyc;
        send_good(8'h55);
        idle(20);
        got = (dv_bytes.size() > qi) ? dv_bytes[qi] : 8'hxx;
        lat = (dv_cycs.size() > qi) ? dv_cycs[qi] - t0 : -1;
        n_checks++;
        if (dv_cnt - b !== 1) $display("[TB] FAIL single_dv_count: got %0d expected 1", dv_cnt - b);
        else n_pass++;
        n_checks++;
        if (got !== 8'h55) $display("[TB] FAIL single_byte: got %h expected 55", got);
        else n_pass++;
        n_checks++;
        if (lat !== LATENCY) $display("[TB] FAIL single_latency: got %0d expected %0d", lat, LATENCY);
        else n_pass++;
        n_checks++;
        if (err_cnt - e !== 0) $display("[TB] FAIL single_ferr: got %0d expected 0", err_cnt - e);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("[TB] FAIL single_busy_after: got %b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int b, e, qi, gap;
        logic [7:0] g0, g1;
        b  = dv_cnt;
        e  = err_cnt;
        qi = dv_bytes.size();
        send_good(8'hA3);
        send_good(8'h0F);
        idle(20);
        g0  = (dv_bytes.size() > qi)     ? dv_bytes[qi]     : 8'hxx;
        g1  = (dv_bytes.size() > qi + 1) ? dv_bytes[qi + 1] : 8'hxx;
        gap = (dv_cycs.size() > qi + 1)  ? dv_cycs[qi + 1] - dv_cycs[qi] : -1;
        n_checks++;
        if (dv_cnt - b !== 2) $display("[TB] FAIL b2b_dv_count: got %0d expected 2", dv_cnt - b);
        else n_pass++;
        n_checks++;
        if (g0 !== 8'hA3) $display("[TB] FAIL b2b_first_byte: got %h expected a3", g0);
        else n_pass++;
        n_checks++;
        if (g1 !== 8'h0F) $display("[TB] FAIL b2b_second_byte: got %h expected 0f", g1);
        else n_pass++;
        n_checks++;
        if (gap !== FRAME_BITS * CPB) $display("[TB] FAIL b2b_gap: got %0d expected %0d", gap, FRAME_BITS * CPB);
        else n_pass++;
        n_checks++;
        if (err_cnt - e !== 0) $display("[TB] FAIL b2b_ferr: got %0d expected 0", err_cnt - e);
        else n_pass++;
    endtask

    task automatic test_glitch;
        int b, e;
        b  = dv_cnt;
        e  = err_cnt;
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) $display("[TB] FAIL glitch_busy_during: got %b expected 1", busy);
        else n_pass++;
        idle(30);
        n_checks++;
        if (dv_cnt - b !== 0 || err_cnt - e !== 0)
            $display("[TB] FAIL glitch_pulses: got dv %0d err %0d expected 0 0", dv_cnt - b, err_cnt - e);
        else n_pass++;
        n_checks++;
        if (rx_byte !== 8'h0F) $display("[TB] FAIL glitch_byte: got %h expected 0f", rx_byte);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("[TB] FAIL glitch_busy_after: got %b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_frame_error;
        int b, e, qi;
        logic [7:0] got;
        b  = dv_cnt;
        e  = err_cnt;
        qi = dv_bytes.size();
        send_frame(8'hC3, ^8'hC3, 1'b0);
        rx = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        n_checks++;
        if (err_cnt - e !== 1) $display("[TB] FAIL ferr_count: got %0d expected 1", err_cnt - e);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b1) $display("[TB] FAIL ferr_break_busy: got %b expected 1", busy);
        else n_pass++;
        n_checks++;
        if (rx_byte !== 8'h0F || dv_cnt - b !== 0)
            $display("[TB] FAIL ferr_byte_held: got %h dv %0d expected 0f dv 0", rx_byte, dv_cnt - b);
        else n_pass++;
        idle(2 * CPB);
        send_good(8'h7E);
        idle(20);
        got = (dv_bytes.size() > qi) ? dv_bytes[qi] : 8'hxx;
        n_checks++;
        if (dv_cnt - b !== 1 || got !== 8'h7E)
            $display("[TB] FAIL ferr_recover: got dv %0d byte %h expected dv 1 byte 7e", dv_cnt - b, got);
        else n_pass++;
        n_checks++;
        if (err_cnt - e !== 1) $display("[TB] FAIL ferr_no_extra: got %0d expected 1", err_cnt - e);
        else n_pass++;
    endtask

    task automatic test_reset_midframe;
        int b, e;
        b = dv_cnt;
        e = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5 * CPB);
        n_checks++;
        if (dv_cnt - b !== 0 || err_cnt - e !== 0)
            $display("[TB] FAIL rstmid_pulses: got dv %0d err %0d expected 0 0", dv_cnt - b, err_cnt - e);
        else n_pass++;
        n_checks++;
        if (rx_byte !== 8'h00) $display("[TB] FAIL rstmid_byte: got %h expected 00", rx_byte);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("[TB] FAIL rstmid_busy: got %b expected 0", busy);
        else n_pass++;
        send_good(8'h12);
        idle(20);
        n_checks++;
        if (dv_cnt - b !== 1 || rx_byte !== 8'h12)
            $display("[TB] FAIL rstmid_next_frame: got dv %0d byte %h expected dv 1 byte 12", dv_cnt - b, rx_byte);
        else n_pass++;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int b, p;
        b = dv_cnt;
        p = perr_cnt;
        send_frame(8'h81, 1'b1, 1'b1);
        idle(20);
        n_checks++;
        if (perr_cnt - p !== 1 || dv_cnt - b !== 0)
            $display("[TB] FAIL parity_bad: got perr %0d dv %0d expected 1 0", perr_cnt - p, dv_cnt - b);
        else n_pass++;
        n_checks++;
        if (rx_byte !== 8'h12) $display("[TB] FAIL parity_byte_held: got %h expected 12", rx_byte);
        else n_pass++;
        send_frame(8'h81, 1'b0, 1'b1);
        idle(20);
        n_checks++;
        if (dv_cnt - b !== 1 || rx_byte !== 8'h81 || perr_cnt - p !== 1)
            $display("[TB] FAIL parity_good: got dv %0d byte %h perr %0d expected 1 81 1",
                     dv_cnt - b, rx_byte, perr_cnt - p);
        else n_pass++;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        @(posedge clk);
        #1;
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_glitch;
        test_frame_error;
        test_reset_midframe;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        n_checks++;
        if (overlap_cnt !== 0) $display("[TB] FAIL dv_err_overlap: got %0d expected 0", overlap_cnt);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- UART receiver for the UART subsystem: converts the serial line back into bytes.
- Sits at the receive end of the link, fed by the UART transmitter's serial output.
- Output pair `o_Rx_dv`/`o_Rx_byte` is what system checkers compare against expected data.
- Frame format: 8N1, LSB first, fixed baud set by a clock-divider parameter, mid-bit sampling.

Parameters:
- CLKS_PER_BIT, default 87, clk cycles per serial bit (must be >= 4).
- SYNC_STAGES, default 2, flop count of the input synchronizer (must be >= 2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- i_Rx_serial  input  1  asynchronous serial line, idle high.
- o_Rx_dv  output  1  one-cycle pulse: `o_Rx_byte` holds a newly received valid byte.
- o_Rx_byte  output  8  last correctly received byte; held until the next good frame.
- o_Frame_err  output  1  one-cycle pulse: stop bit sampled low.
- o_Rx_busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE; bit counter and clock counter = 0.
  - o_Rx_dv = 0, o_Frame_err = 0, o_Rx_busy = 0, o_Rx_byte = 8'h00.
  - Synchronizer flops preset to 1 (idle line).
  - Reset mid-frame aborts the frame silently: no dv, no err.
- i_Rx_serial passes through SYNC_STAGES flops; all decisions use the synchronized bit `rx_s`.
- Clock counter `clk_cnt` is $clog2(CLKS_PER_BIT) bits wide and cleared on every state change.
- Data-bit index `bit_idx` is 3 bits, 0..7.
- IDLE:
  - `rx_s` == 0 -> START, `clk_cnt` = 0.
- START:
  - At `clk_cnt` == (CLKS_PER_BIT-1)/2 (mid start bit), sample `rx_s`.
  - 0 -> DATA, `bit_idx` = 0.
  - 1 -> IDLE (glitch rejected, no pulse).
- DATA:
  - At `clk_cnt` == CLKS_PER_BIT-1, shift `rx_s` into `shift_reg[bit_idx]` (LSB first).
  - `bit_idx` < 7 -> increment `bit_idx`, stay in DATA.
  - `bit_idx` == 7 -> STOP.
- STOP:
  - At `clk_cnt` == CLKS_PER_BIT-1, sample `rx_s`.
  - 1 -> `o_Rx_byte` <= `shift_reg`, `o_Rx_dv` <= 1 for exactly one cycle, -> IDLE.
  - 0 -> `o_Frame_err` <= 1 for one cycle, `o_Rx_byte` unchanged, -> BREAK.
- BREAK:
  - Waits for `rx_s` == 1, then -> IDLE.
  - Prevents a held-low line (break) from being parsed as back-to-back frames.
- Latency:
  - `o_Rx_dv` rises the cycle after the stop-bit mid-sample edge.
  - Measured from the line's start-bit falling edge: SYNC_STAGES + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 2 clk cycles.
- Back-to-back frames:
  - Returning to IDLE at the stop-bit mid-sample leaves about half a bit for the next start edge to be detected.
  - Continuous transmission at the nominal rate receives with no loss.
- `o_Rx_dv` and `o_Frame_err` are never high in the same cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: a PARITY state sits between DATA and STOP and samples at CLKS_PER_BIT-1.
  - Received parity must equal ^`shift_reg` (even).
  - Mismatch: frame is still completed through STOP; at STOP the output is `o_Parity_err` (extra 1-bit output port, one-cycle pulse) instead of `o_Rx_dv`; `o_Rx_byte` unchanged.
  - A frame error takes priority over a parity error.
- Undefined:
  - No PARITY state and no `o_Parity_err` port; 8N1 only.

Decomposition:
- Package `uart_pkg`:
  - `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP, BREAK).
  - `UART_DATA_BITS` = 8.
  - Shared default for CLKS_PER_BIT, also used by the UART transmitter.
- Sub-module `sync_ff`: parameterized N-stage synchronizer with reset-preset value 1; reused elsewhere for async inputs.

Test Plan (CLKS_PER_BIT=16, SYNC_STAGES=2):
- Drive 8N1 frame 8'h55 -> exactly one `o_Rx_dv` pulse, `o_Rx_byte` = 8'h55, `o_Frame_err` stays 0, `o_Rx_busy` low after.
- Two back-to-back frames 8'hA3, 8'h0F with no idle gap -> two `o_Rx_dv` pulses 160 cycles apart, bytes 8'hA3 then 8'h0F.
- Low glitch of 5 cycles on an idle line -> returns to IDLE, no dv/err, `o_Rx_byte` unchanged.
- Frame 8'hC3 with stop bit forced 0, line held low 40 more cycles, then 8'h7E -> one `o_Frame_err` pulse, `o_Rx_byte` stays at previous value; after line goes high the next frame gives `o_Rx_dv` with 8'h7E.
- rst_n pulsed low during bit 4 of frame 8'hFF -> no pulses, `o_Rx_byte` = 8'h00; next frame 8'h12 received correctly.
- With UART_RX_PARITY_EN: frame 8'h81 with parity bit 1 (wrong) -> `o_Parity_err` pulse, no `o_Rx_dv`; with parity bit 0 -> `o_Rx_dv`, byte 8'h81.
